// File: rtl/lcplc_stream_sequencer.sv
// rtl/lcplc_stream_sequencer.sv - LCPLC coder front-end: config latch, sample pass-through, framing flags
//
// Accepts one image configuration at a time, forwards raw samples to the coder
// with zero latency, tags each sample with row/slice/band/image framing flags,
// then waits for the coder's final output word before accepting the next image.
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   cfg_valid/cfg_ready           configuration handshake (accepted only in IDLE)
//   cfg_block_rows/cols/bands/blocks, cfg_shift_in, cfg_threshold_in  configuration fields
//   in_valid/in_ready/in_data     raw sample stream in
//   x_valid/x_ready/x_data        sample stream to coder
//   x_last_r/s/b/i                framing flags (row, block-in-band, last band, image)
//   cfg_quant_shift/cfg_threshold latched quantizer settings for the current image
//   coder_out_valid/ready/last    coder output handshake, monitored only
//   busy, done, cfg_err           status: not idle, image finished pulse, bad config pulse
module lcplc_stream_sequencer #(
  parameter int DATA_WIDTH            = 16,
  parameter int MAX_SLICE_SIZE_LOG    = 12,
  parameter int BAND_WIDTH            = 8,
  parameter int BLOCK_COUNT_WIDTH     = 16,
  parameter int QUANTIZER_SHIFT_WIDTH = 4,
  parameter int THRESHOLD_WIDTH       = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [MAX_SLICE_SIZE_LOG-1:0]    cfg_block_rows,
  input  logic [MAX_SLICE_SIZE_LOG-1:0]    cfg_block_cols,
  input  logic [BAND_WIDTH-1:0]            cfg_bands,
  input  logic [BLOCK_COUNT_WIDTH-1:0]     cfg_blocks,
  input  logic [QUANTIZER_SHIFT_WIDTH-1:0] cfg_shift_in,
  input  logic [THRESHOLD_WIDTH-1:0]       cfg_threshold_in,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic                             x_valid,
  input  logic                             x_ready,
  output logic [DATA_WIDTH-1:0]            x_data,
  output logic                             x_last_r,
  output logic                             x_last_s,
  output logic                             x_last_b,
  output logic                             x_last_i,
  output logic [QUANTIZER_SHIFT_WIDTH-1:0] cfg_quant_shift,
  output logic [THRESHOLD_WIDTH-1:0]       cfg_threshold,
  input  logic                             coder_out_valid,
  input  logic                             coder_out_ready,
  input  logic                             coder_out_last,
  output logic                             busy,
  output logic                             done,
  output logic                             cfg_err
);

  localparam int MSSL = MAX_SLICE_SIZE_LOG;
  localparam int BW   = BAND_WIDTH;
  localparam int BCW  = BLOCK_COUNT_WIDTH;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t state_q, state_d;

  logic [MSSL-1:0]                  rows_q, rows_d, cols_q, cols_d;
  logic [BW-1:0]                    bands_q, bands_d;
  logic [BCW-1:0]                   blocks_q, blocks_d;
  logic [QUANTIZER_SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic [THRESHOLD_WIDTH-1:0]       thr_q, thr_d;
  logic [MSSL-1:0]                  col_q, col_d, row_q, row_d;
  logic [BW-1:0]                    band_q, band_d;
  logic [BCW-1:0]                   blk_q, blk_d;
  logic                             done_q, done_d, cfg_err_q, cfg_err_d;

  logic cfg_hs, x_hs, coder_last_hs, cfg_zero;
  logic end_col, end_row, end_band, end_blk;

  assign cfg_hs        = cfg_valid && cfg_ready;
  assign x_hs          = x_valid && x_ready;
  assign coder_last_hs = coder_out_valid && coder_out_ready && coder_out_last;
  assign cfg_zero      = (cfg_block_rows == '0) || (cfg_block_cols == '0) ||
                         (cfg_bands == '0) || (cfg_blocks == '0);

  // Compare against field-1 at full field width; fields are never 0 while
  // streaming, so the subtraction cannot wrap.
  assign end_col  = (col_q  == cols_q   - MSSL'(1));
  assign end_row  = (row_q  == rows_q   - MSSL'(1));
  assign end_band = (band_q == bands_q  - BW'(1));
  assign end_blk  = (blk_q  == blocks_q - BCW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_hs && !cfg_zero) state_d = STREAM;
      STREAM:  if (x_hs && x_last_i) state_d = DRAIN;
      DRAIN:   if (coder_last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: STREAM is a pure combinational pass-through
  always_comb begin
    cfg_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    x_valid   = (state_q == STREAM) && in_valid;
    in_ready  = (state_q == STREAM) && x_ready;
  end

  assign x_data   = in_data;
  assign x_last_r = x_valid && end_col;
  assign x_last_s = x_last_r && end_row;
  assign x_last_b = x_last_s && end_band;
  assign x_last_i = x_last_b && end_blk;

  // Configuration latch and position counters
  always_comb begin
    rows_d    = rows_q;
    cols_d    = cols_q;
    bands_d   = bands_q;
    blocks_d  = blocks_q;
    shift_d   = shift_q;
    thr_d     = thr_q;
    col_d     = col_q;
    row_d     = row_q;
    band_d    = band_q;
    blk_d     = blk_q;
    done_d    = (state_q == DRAIN) && coder_last_hs;
    cfg_err_d = cfg_hs && cfg_zero;
    if (cfg_hs) begin
      rows_d   = cfg_block_rows;
      cols_d   = cfg_block_cols;
      bands_d  = cfg_bands;
      blocks_d = cfg_blocks;
      shift_d  = cfg_shift_in;
      thr_d    = cfg_threshold_in;
      col_d    = '0;
      row_d    = '0;
      band_d   = '0;
      blk_d    = '0;
    end else if (x_hs) begin
      if (!end_col) begin
        col_d = col_q + MSSL'(1);
      end else begin
        col_d = '0;
        if (!end_row) begin
          row_d = row_q + MSSL'(1);
        end else begin
          row_d = '0;
          if (!end_band) begin
            band_d = band_q + BW'(1);
          end else begin
            band_d = '0;
            blk_d  = end_blk ? '0 : blk_q + BCW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rows_q    <= '0;
      cols_q    <= '0;
      bands_q   <= '0;
      blocks_q  <= '0;
      shift_q   <= '0;
      thr_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      band_q    <= '0;
      blk_q     <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      bands_q   <= bands_d;
      blocks_q  <= blocks_d;
      shift_q   <= shift_d;
      thr_q     <= thr_d;
      col_q     <= col_d;
      row_q     <= row_d;
      band_q    <= band_d;
      blk_q     <= blk_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_quant_shift = shift_q;
  assign cfg_threshold   = thr_q;
  assign done            = done_q;
  assign cfg_err         = cfg_err_q;

endmodule

// File: tb/tb_lcplc_stream_sequencer.sv
// tb/tb_lcplc_stream_sequencer.sv - self-checking bench for lcplc_stream_sequencer
module tb_lcplc_stream_sequencer;

  localparam int DW = 16, MSSL = 12, BW = 8, BCW = 16, QSW = 4, TW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_valid, cfg_ready;
  logic [MSSL-1:0] cfg_block_rows, cfg_block_cols;
  logic [BW-1:0]   cfg_bands;
  logic [BCW-1:0]  cfg_blocks;
  logic [QSW-1:0]  cfg_shift_in;
  logic [TW-1:0]   cfg_threshold_in;
  logic            in_valid, in_ready;
  logic [DW-1:0]   in_data;
  logic            x_valid, x_ready;
  logic [DW-1:0]   x_data;
  logic            x_last_r, x_last_s, x_last_b, x_last_i;
  logic [QSW-1:0]  cfg_quant_shift;
  logic [TW-1:0]   cfg_threshold;
  logic            coder_out_valid, coder_out_ready, coder_out_last;
  logic            busy, done, cfg_err;

  always #5 clk = ~clk;

  lcplc_stream_sequencer dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_block_rows(cfg_block_rows), .cfg_block_cols(cfg_block_cols),
    .cfg_bands(cfg_bands), .cfg_blocks(cfg_blocks),
    .cfg_shift_in(cfg_shift_in), .cfg_threshold_in(cfg_threshold_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .x_last_r(x_last_r), .x_last_s(x_last_s), .x_last_b(x_last_b), .x_last_i(x_last_i),
    .cfg_quant_shift(cfg_quant_shift), .cfg_threshold(cfg_threshold),
    .coder_out_valid(coder_out_valid), .coder_out_ready(coder_out_ready),
    .coder_out_last(coder_out_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  typedef struct {
    int          rows, cols, bands, blocks;
    int          shift;
    logic [63:0] thr;
    bit          full_rate;
    int          drain_wait;
    bit          exp_err;
    int          exp_r, exp_s, exp_b;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference framing computed from the flat sample index of the block-major order.
  function automatic logic [3:0] model_flags(input vec_t v, input int n);
    int per_row, per_slice, per_block, total;
    logic lr, ls, lb, li;
    per_row   = v.cols;
    per_slice = v.cols * v.rows;
    per_block = per_slice * v.bands;
    total     = per_block * v.blocks;
    lr = ((n + 1) % per_row)   == 0;
    ls = ((n + 1) % per_slice) == 0;
    lb = ((n + 1) % per_block) == 0;
    li = (n + 1) == total;
    return {li, lb, ls, lr};
  endfunction

  task automatic quiet_inputs();
    cfg_valid        = 1'b0;
    cfg_block_rows   = '0;
    cfg_block_cols   = '0;
    cfg_bands        = '0;
    cfg_blocks       = '0;
    cfg_shift_in     = '0;
    cfg_threshold_in = '0;
    in_valid         = 1'b0;
    in_data          = '0;
    x_ready          = 1'b0;
    coder_out_valid  = 1'b0;
    coder_out_ready  = 1'b0;
    coder_out_last   = 1'b0;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic apply_cfg(input vec_t v);
    cfg_valid        = 1'b1;
    cfg_block_rows   = MSSL'(v.rows);
    cfg_block_cols   = MSSL'(v.cols);
    cfg_bands        = BW'(v.bands);
    cfg_blocks       = BCW'(v.blocks);
    cfg_shift_in     = QSW'(v.shift);
    cfg_threshold_in = v.thr;
    #1;
    check("cfg_ready_idle", cfg_ready, 1'b1);
    @(negedge clk);
    cfg_valid = 1'b0;
    #1;
    check("cfg_err_pulse", cfg_err, v.exp_err);
    check("busy_after_cfg", busy, !v.exp_err);
    check("done_one_cycle", done, 1'b0);
    check("shift_latched", cfg_quant_shift, 64'(v.shift));
    check("thr_latched", cfg_threshold, v.thr);
    if (v.exp_err) begin
      @(negedge clk);
      #1;
      check("cfg_err_cleared", cfg_err, 1'b0);
      check("busy_err_idle", busy, 1'b0);
      check("cfg_ready_err_idle", cfg_ready, 1'b1);
    end
  endtask

  // Streams samples until `limit` transfers; ends just after a falling edge.
  task automatic stream(input vec_t v, input int limit);
    int          n, cycles, budget, total, cnt_r, cnt_s, cnt_b, cnt_i;
    bit          stalled;
    logic [3:0]  req, held_flags;
    logic [DW-1:0] held_data;
    total   = v.rows * v.cols * v.bands * v.blocks;
    budget  = limit * 20 + 50;
    n = 0; cycles = 0; stalled = 0;
    cnt_r = 0; cnt_s = 0; cnt_b = 0; cnt_i = 0;
    held_flags = '0; held_data = '0;
    while (n < limit && cycles < budget) begin
      if (stalled) begin
        in_valid = 1'b1;
        in_data  = held_data;
      end else begin
        in_valid = v.full_rate ? 1'b1 : ($urandom_range(0, 3) != 0);
        in_data  = DW'($urandom);
      end
      x_ready = v.full_rate ? 1'b1 : ($urandom_range(0, 2) != 0);
      // Offered configurations and coder handshakes must be ignored while streaming.
      cfg_valid        = $urandom_range(0, 1);
      cfg_block_rows   = MSSL'($urandom);
      cfg_shift_in     = QSW'($urandom);
      coder_out_valid  = $urandom_range(0, 1);
      coder_out_ready  = $urandom_range(0, 1);
      coder_out_last   = $urandom_range(0, 1);
      if (in_valid && x_ready && n == total - 1) begin
        coder_out_valid = 1'b1;
        coder_out_ready = 1'b1;
        coder_out_last  = 1'b1;
      end
      #1;
      req = model_flags(v, n);
      check("x_valid_pass", x_valid, in_valid);
      check("in_ready_pass", in_ready, x_ready);
      check("busy_stream", busy, 1'b1);
      check("cfg_ready_stream", cfg_ready, 1'b0);
      check("shift_stable", cfg_quant_shift, 64'(v.shift));
      if (in_valid) begin
        check("x_data_pass", x_data, in_data);
        check("flags", {x_last_i, x_last_b, x_last_s, x_last_r}, req);
      end
      if (stalled) begin
        check("stall_data_hold", x_data, held_data);
        check("stall_flags_hold", {x_last_i, x_last_b, x_last_s, x_last_r}, held_flags);
      end
      held_data  = x_data;
      held_flags = {x_last_i, x_last_b, x_last_s, x_last_r};
      @(posedge clk);
      if (in_valid && x_ready) begin
        cnt_r += int'(req[0]);
        cnt_s += int'(req[1] & x_last_s);
        cnt_b += int'(x_last_b);
        cnt_i += int'(x_last_i);
        n++;
      end
      stalled = in_valid && !x_ready;
      cycles++;
      @(negedge clk);
      quiet_inputs();
    end
    check("stream_done_in_budget", 64'(n), 64'(limit));
    if (limit == total) begin
      check("count_last_s", 64'(cnt_s), 64'(v.exp_s));
      check("count_last_b", 64'(cnt_b), 64'(v.exp_b));
      check("count_last_i", 64'(cnt_i), 64'd1);
      check("count_last_r", 64'(cnt_r), 64'(v.exp_r));
    end
  endtask

  // Holds the DRAIN state for `wait_cycles`, then completes the coder handshake.
  task automatic drain(input int wait_cycles);
    for (int d = 0; d < wait_cycles; d++) begin
      in_valid        = 1'b1;
      x_ready         = 1'b1;
      cfg_valid       = 1'b1;
      coder_out_valid = $urandom_range(0, 1);
      coder_out_ready = $urandom_range(0, 1);
      coder_out_last  = !(coder_out_valid && coder_out_ready);
      #1;
      check("drain_in_ready", in_ready, 1'b0);
      check("drain_x_valid", x_valid, 1'b0);
      check("drain_busy", busy, 1'b1);
      check("drain_cfg_ready", cfg_ready, 1'b0);
      check("drain_no_done", done, 1'b0);
      @(negedge clk);
      quiet_inputs();
    end
    coder_out_valid = 1'b1;
    coder_out_ready = 1'b1;
    coder_out_last  = 1'b1;
    @(negedge clk);
    quiet_inputs();
    #1;
    check("done_pulse", done, 1'b1);
    check("idle_after_done", busy, 1'b0);
    check("cfg_ready_after_done", cfg_ready, 1'b1);
  endtask

  vec_t vecs[8];

  initial begin
    //         rows cols bands blocks shift thr                   full wait err  r   s  b
    vecs[0] = '{2, 2, 2, 1,  2, 64'h100000,           1'b1, 5, 1'b0, 4,  2, 1};
    vecs[1] = '{2, 2, 2, 2,  5, 64'h123,              1'b1, 3, 1'b0, 8,  4, 2};
    vecs[2] = '{2, 0, 2, 1,  7, 64'h55,               1'b0, 1, 1'b1, 0,  0, 0};
    vecs[3] = '{1, 1, 1, 1,  1, 64'h1,                1'b0, 1, 1'b0, 1,  1, 1};
    vecs[4] = '{3, 4, 2, 2, 15, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4, 1'b0, 12, 4, 2};
    vecs[5] = '{2, 3, 3, 1,  9, 64'hDEAD_BEEF_0000_0001, 1'b0, 2, 1'b0, 6,  3, 1};
    vecs[6] = '{1, 5, 1, 3,  3, 64'h8000_0000_0000_0000, 1'b0, 6, 1'b0, 3,  3, 3};
    vecs[7] = '{3, 2, 1, 0,  4, 64'h77,               1'b0, 1, 1'b1, 0,  0, 0};

    quiet_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    check("rst_cfg_ready", cfg_ready, 1'b1);
    check("rst_shift", cfg_quant_shift, 64'd0);
    check("rst_thr", cfg_threshold, 64'd0);
    in_valid = 1'b1;
    x_ready  = 1'b1;
    #1;
    check("rst_x_valid", x_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    quiet_inputs();

    for (int i = 0; i < 8; i++) begin
      apply_cfg(vecs[i]);
      if (!vecs[i].exp_err) begin
        stream(vecs[i], vecs[i].rows * vecs[i].cols * vecs[i].bands * vecs[i].blocks);
        drain(vecs[i].drain_wait);
      end
    end

    // Reset after three samples aborts the image; a full rerun then frames identically.
    apply_cfg(vecs[0]);
    stream(vecs[0], 3);
    rst = 1'b0;
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    x_ready  = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_cfg_ready", cfg_ready, 1'b1);
    check("abort_x_valid", x_valid, 1'b0);
    check("abort_shift", cfg_quant_shift, 64'd0);
    quiet_inputs();
    apply_cfg(vecs[0]);
    stream(vecs[0], 8);
    drain(vecs[0].drain_wait);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
